// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencer for an external min:sec counter chain
// Prescaled count tick, counter clear, 59:59 saturation, lap freeze and BCD display split.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int MAX_MIN  = 59,
  parameter int MAX_SEC  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       tick,
  output logic       cnt_clr,
  output logic [1:0] state,
  output logic       ovf,
  output logic [3:0] disp_min1,
  output logic [3:0] disp_min2,
  output logic [3:0] disp_sec1,
  output logic [3:0] disp_sec2
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic          r_tick;
  logic          r_cnt_clr;
  logic          r_ovf;
  logic          w_ovf_nxt;
  logic          w_lap_load;
  logic [5:0]    r_lap_min;
  logic [5:0]    r_lap_sec;
  logic [5:0]    w_src_min;
  logic [5:0]    w_src_sec;
  logic          w_counting;
  logic          w_terminal;
  logic          w_sat;
  logic [3:0]    r_disp_min1;
  logic [3:0]    r_disp_min2;
  logic [3:0]    r_disp_sec1;
  logic [3:0]    r_disp_sec2;

  assign w_counting = (r_state == RUN) || (r_state == LAP);
  assign w_terminal = w_counting && (r_pre == PRE_LAST);
  // A terminal at the maximum time would roll the counters; stop instead.
  assign w_sat      = w_terminal && (cur_min == 6'(MAX_MIN)) && (cur_sec == 6'(MAX_SEC));

  always_comb begin
    w_state_nxt = r_state;
    w_ovf_nxt   = r_ovf;
    w_lap_load  = 1'b0;
    if (w_sat) begin
      w_state_nxt = PAUSE;
      w_ovf_nxt   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (btn_start) w_state_nxt = RUN;
        end
        RUN: begin
          if (btn_start) begin
            w_state_nxt = PAUSE;
          end else if (btn_lap) begin
            w_state_nxt = LAP;
            w_lap_load  = 1'b1;
          end
        end
        LAP: begin
          if (btn_start)    w_state_nxt = PAUSE;
          else if (btn_lap) w_state_nxt = RUN;
        end
        PAUSE: begin
          if (btn_start) begin
            if (!r_ovf) w_state_nxt = RUN;
          end else if (btn_lap) begin
            w_state_nxt = IDLE;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_pre_nxt = r_pre;
    case (r_state)
      IDLE:    w_pre_nxt = '0;
      PAUSE:   w_pre_nxt = r_pre;
      default: w_pre_nxt = w_terminal ? '0 : r_pre + PW'(1);
    endcase
  end

  assign w_src_min = (r_state == LAP) ? r_lap_min : cur_min;
  assign w_src_sec = (r_state == LAP) ? r_lap_sec : cur_sec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pre       <= '0;
      r_tick      <= 1'b0;
      r_cnt_clr   <= 1'b1;
      r_ovf       <= 1'b0;
      r_lap_min   <= '0;
      r_lap_sec   <= '0;
      r_disp_min1 <= '0;
      r_disp_min2 <= '0;
      r_disp_sec1 <= '0;
      r_disp_sec2 <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pre       <= w_pre_nxt;
      r_tick      <= w_terminal && !w_sat;
      r_cnt_clr   <= (w_state_nxt == IDLE);
      r_ovf       <= w_ovf_nxt;
      if (w_lap_load) begin
        r_lap_min <= cur_min;
        r_lap_sec <= cur_sec;
      end
      r_disp_min1 <= 4'(w_src_min / 6'd10);
      r_disp_min2 <= 4'(w_src_min % 6'd10);
      r_disp_sec1 <= 4'(w_src_sec / 6'd10);
      r_disp_sec2 <= 4'(w_src_sec % 6'd10);
    end
  end

  assign tick      = r_tick;
  assign cnt_clr   = r_cnt_clr;
  assign state     = r_state;
  assign ovf       = r_ovf;
  assign disp_min1 = r_disp_min1;
  assign disp_min2 = r_disp_min2;
  assign disp_sec1 = r_disp_sec1;
  assign disp_sec2 = r_disp_sec2;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - bench for stopwatch_ctrl with an ideal min:sec counter attached
// Directed scenarios then random buttons, checked against a cycle-level reference model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start, btn_lap;
  logic [5:0] cur_min, cur_sec;
  logic       tick, cnt_clr, ovf;
  logic [1:0] state;
  logic [3:0] disp_min1, disp_min2, disp_sec1, disp_sec2;

  logic       pl_req;
  logic [5:0] pl_min, pl_sec;

  int n_tests = 0;
  int n_fail  = 0;

  int m_st, m_pre, m_tick, m_clr, m_ovf, m_lap_min, m_lap_sec;
  int m_dm1, m_dm2, m_ds1, m_ds2;

  stopwatch_ctrl #(.TICK_DIV(TD), .MAX_MIN(59), .MAX_SEC(59)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap),
    .cur_min(cur_min), .cur_sec(cur_sec), .tick(tick), .cnt_clr(cnt_clr),
    .state(state), .ovf(ovf), .disp_min1(disp_min1), .disp_min2(disp_min2),
    .disp_sec1(disp_sec1), .disp_sec2(disp_sec2)
  );

  always #5 clk = ~clk;

  // Ideal external second/minute counter chain
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_min <= '0;
      cur_sec <= '0;
    end else if (pl_req) begin
      cur_min <= pl_min;
      cur_sec <= pl_sec;
    end else if (cnt_clr) begin
      cur_min <= '0;
      cur_sec <= '0;
    end else if (tick) begin
      if (cur_sec == 6'd59) begin
        cur_sec <= '0;
        cur_min <= cur_min + 6'd1;
      end else begin
        cur_sec <= cur_sec + 6'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_pre = 0; m_tick = 0; m_clr = 1; m_ovf = 0;
    m_lap_min = 0; m_lap_sec = 0;
    m_dm1 = 0; m_dm2 = 0; m_ds1 = 0; m_ds2 = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT will sample.
  task automatic model_next(input bit bs, input bit bl, input int cm, input int cs);
    bit running, term, sat;
    int ns, vm, vs;
    running = (m_st == S_RUN) || (m_st == S_LAP);
    term    = running && (m_pre == TD - 1);
    sat     = term && (cm == 59) && (cs == 59);
    vm = (m_st == S_LAP) ? m_lap_min : cm;
    vs = (m_st == S_LAP) ? m_lap_sec : cs;
    m_dm1 = vm / 10; m_dm2 = vm % 10; m_ds1 = vs / 10; m_ds2 = vs % 10;
    ns = m_st;
    if (sat) begin
      ns = S_PAUSE;
      m_ovf = 1;
    end else if (bs) begin
      if (m_st == S_IDLE) ns = S_RUN;
      else if (m_st == S_RUN || m_st == S_LAP) ns = S_PAUSE;
      else if (m_ovf == 0) ns = S_RUN;
    end else if (bl) begin
      if (m_st == S_RUN) begin
        ns = S_LAP; m_lap_min = cm; m_lap_sec = cs;
      end else if (m_st == S_LAP) begin
        ns = S_RUN;
      end else if (m_st == S_PAUSE) begin
        ns = S_IDLE; m_ovf = 0;
      end
    end
    if (m_st == S_IDLE) m_pre = 0;
    else if (running) m_pre = (m_pre + 1) % TD;
    m_tick = (term && !sat) ? 1 : 0;
    m_st   = ns;
    m_clr  = (ns == S_IDLE) ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_disp;
    exp_disp = {4'(m_dm1), 4'(m_dm2), 4'(m_ds1), 4'(m_ds2)};
    chk({tag, "_state"}, 32'(state), 32'(m_st));
    chk({tag, "_tick"}, 32'(tick), 32'(m_tick));
    chk({tag, "_cnt_clr"}, 32'(cnt_clr), 32'(m_clr));
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, "_disp"}, 32'({disp_min1, disp_min2, disp_sec1, disp_sec2}), 32'(exp_disp));
  endtask

  // Entered and left at a falling edge.
  task automatic step(input bit bs, input bit bl);
    btn_start = bs;
    btn_lap   = bl;
    model_next(bs, bl, int'(cur_min), int'(cur_sec));
    @(posedge clk);
    #1;
    check_all("step");
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    @(negedge clk);
  endtask

  task automatic preload(input logic [5:0] mn, input logic [5:0] sc);
    pl_min = mn; pl_sec = sc; pl_req = 1'b1;
    step(1'b0, 1'b0);
    pl_req = 1'b0;
  endtask

  task automatic wait_cur(input string tag, input logic [5:0] mn, input logic [5:0] sc, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cur_min == mn && cur_sec == sc) break;
      step(1'b0, 1'b0);
    end
    chk(tag, 32'({cur_min, cur_sec}), 32'({mn, sc}));
  endtask

  initial begin
    rst = 1'b0; btn_start = 1'b0; btn_lap = 1'b0;
    pl_req = 1'b0; pl_min = '0; pl_sec = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_all("reset");

    // Start from IDLE; lap presses before it must be ignored
    for (int i = 0; i < 9; i++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0);
    chk("start_state", 32'(state), 32'(2'b01));
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0);
    chk("count_0003", 32'({cur_min, cur_sec}), 32'({6'd0, 6'd3}));

    // Pause mid-period, then resume with the remaining prescale count
    wait_cur("reach_0005", 6'd0, 6'd5, 40);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);

    // Lap freeze at 01:07 while the counters keep running
    preload(6'd1, 6'd6);
    wait_cur("reach_0107", 6'd1, 6'd7, 20);
    step(1'b0, 1'b1);
    wait_cur("reach_0110", 6'd1, 6'd10, 30);
    chk("lap_hold", 32'({disp_min1, disp_min2, disp_sec1, disp_sec2}), 32'(16'h0107));
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Saturation at 59:59
    preload(6'd59, 6'd58);
    for (int i = 0; i < 20 && m_ovf == 0; i++) step(1'b0, 1'b0);
    chk("sat_state", 32'(state), 32'(2'b10));
    chk("sat_ovf", 32'(ovf), 32'd1);
    step(1'b1, 1'b0);
    chk("sat_start_ignored", 32'(state), 32'(2'b10));
    step(1'b0, 1'b1);
    chk("sat_clear_state", 32'(state), 32'(2'b00));
    chk("sat_clear_cnt_clr", 32'(cnt_clr), 32'd1);

    // Simultaneous buttons: start wins
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("both_run", 32'(state), 32'(2'b10));
    step(1'b1, 1'b1);
    chk("both_pause", 32'(state), 32'(2'b01));

    // Asynchronous reset just before a tick would fire
    for (int i = 0; i < 2 * TD && !(m_st == S_RUN && m_pre == TD - 1); i++) step(1'b0, 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    rst = 1'b1;

    // Random button traffic with occasional preloads near the limit
    for (int i = 0; i < 600; i++) begin
      if (m_st == S_RUN && $urandom_range(0, 39) == 0)
        preload(6'd59, 6'($urandom_range(54, 59)));
      else
        step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
